// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-type encodings, RX frame FSM states and
// the legal ranges of the frame-format parameters.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'd0;
  localparam logic [1:0] PAR_ODD   = 2'd1;
  localparam logic [1:0] PAR_MARK  = 2'd2;
  localparam logic [1:0] PAR_SPACE = 2'd3;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Expected parity bit from the running XOR of the data bits and the parity type.
// Purely combinational so the TX serializer can share it.
module uart_parity_calc
  import uart_pkg::*;
(
  input  logic       run_parity_i,
  input  logic [1:0] par_type_i,
  output logic       exp_bit_o
);

  always_comb begin
    exp_bit_o = run_parity_i;
    case (par_type_i)
      PAR_EVEN:  exp_bit_o = run_parity_i;
      PAR_ODD:   exp_bit_o = ~run_parity_i;
      PAR_MARK:  exp_bit_o = 1'b1;
      PAR_SPACE: exp_bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// Assembles one UART frame (data LSB first, optional parity, 1-2 stop bits) from
// sampled-bit strobes; word and error flags update with a data_valid pulse one cycle after the last stop strobe.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  samp_valid,
  input  logic                  samp_data_in,
  input  logic                  par_check_enable,
  input  logic [1:0]            par_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_cfg
    $error("uart_rx_frame_check: illegal DATA_WIDTH/STOP_BITS");
  end

  rx_state_e             state_q;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_run_q, par_run_d;
  logic                  stop_flag_q, stop_flag_d;
  logic                  mismatch_q, mismatch_d;
  logic                  par_en_q;
  logic [1:0]            par_type_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  parity_error_q;
  logic                  stop_error_q;
  logic                  par_exp;

  uart_parity_calc u_parity_calc (
    .run_parity_i (par_run_q),
    .par_type_i   (par_type_q),
    .exp_bit_o    (par_exp)
  );

  always_comb begin
    sr_d        = {samp_data_in, sr_q[DATA_WIDTH-1:1]};
    par_run_d   = par_run_q ^ samp_data_in;
    stop_flag_d = stop_flag_q | ~samp_data_in;
    mismatch_d  = (samp_data_in != par_exp);
  end

  // The bit counter is reused to count stop bits; it restarts at each phase change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      sr_q           <= '0;
      cnt_q          <= '0;
      par_run_q      <= 1'b0;
      stop_flag_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      par_en_q       <= 1'b0;
      par_type_q     <= PAR_EVEN;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            par_en_q    <= par_check_enable;
            par_type_q  <= par_type;
            cnt_q       <= '0;
            par_run_q   <= 1'b0;
            stop_flag_q <= 1'b0;
            mismatch_q  <= 1'b0;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (samp_valid) begin
            sr_q      <= sr_d;
            par_run_q <= par_run_d;
            if (cnt_q == DATA_LAST) begin
              cnt_q   <= '0;
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (samp_valid) begin
            mismatch_q <= mismatch_d;
            state_q    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (samp_valid) begin
            stop_flag_q <= stop_flag_d;
            if (cnt_q == STOP_LAST) begin
              cnt_q          <= '0;
              state_q        <= ST_IDLE;
              data_out_q     <= sr_q;
              parity_error_q <= mismatch_q & par_en_q;
              stop_error_q   <= stop_flag_d;
              data_valid_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
